// File: rtl/fifo_async_pkg.sv
// Shared helpers for the asynchronous FIFO pointer-crossing logic.
// Holds the pointer width helper and width-generic gray/binary conversions.
// The conversions work on a MAX_PW-bit container. Narrower pointers are
// zero-extended into it. Zero upper bits have no effect on either direction
// of the conversion, so one function serves every pointer width.
package fifo_async_pkg;

    // Widest pointer that the conversion helpers accept.
    localparam int MAX_PW = 32;

    // Pointer width for a FIFO of the given depth.
    // The extra MSB is the lap bit that separates full from empty.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Binary to reflected gray code.
    function automatic logic [MAX_PW-1:0] bin2gray(input logic [MAX_PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Gray to binary.
    // Binary bit i is the XOR of all gray bits at position i and above.
    function automatic logic [MAX_PW-1:0] gray2bin(input logic [MAX_PW-1:0] g);
        logic [MAX_PW-1:0] b;
        b = '0;
        for (int i = 0; i < MAX_PW; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// Plain multi-flop vector synchroniser.
// It has no logic between stages, so each stage gets a full clock period to
// resolve metastability. Only gray-coded or otherwise single-bit-change
// buses may pass through it. The ASYNC_REG attribute keeps the stages packed
// together and prevents retiming across them.
module sync_ff_chain #(
    parameter int W      = 1,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    (* ASYNC_REG = "TRUE" *) logic [W-1:0] stage_reg [STAGES];

    // Shift the captured value one stage per clock. The reset is asynchronous.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_reg[i] <= '0;
            end
        end else begin
            stage_reg[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage_reg[i] <= stage_reg[i-1];
            end
        end
    end

    assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/wptr_sync_r.sv
// Read-domain receiver for the async FIFO write pointer.
// The gray write pointer from clk_w passes through a SYNC_STAGES flop chain.
// It is then decoded to binary in a register, with no combinational path from
// wptr_gray_w. The block derives a write-advance pulse, the read-side fill
// level and an almost_empty flag.
// Optional macro WPTR_SYNC_CHECK_EN adds a sticky sync_err flag. The flag is
// set when the fill level exceeds depth. Without the macro, sync_err is tied 0.
module wptr_sync_r
    import fifo_async_pkg::*;
#(
    parameter  int depth       = 1024,
    parameter  int SYNC_STAGES = 2,
    parameter  int AE_THRESH   = 1,
    localparam int PW          = ptr_width(depth)
) (
    input  logic          clk_r,
    input  logic          rst_r_gen,
    input  logic [PW-1:0] wptr_gray_w,
    input  logic [PW-1:0] rptr,
    output logic [PW-1:0] wptr_gray_sync,
    output logic [PW-1:0] wptr_bin_sync,
    output logic          wptr_adv,
    output logic [PW-1:0] rd_level,
    output logic          almost_empty,
    output logic          sync_err
);

    // Threshold and legal-range limits at pointer width.
    // depth is a power of two, so it fits in PW bits.
    localparam logic [PW-1:0] AE_LIMIT    = PW'(AE_THRESH);
    localparam logic [PW-1:0] LEVEL_LIMIT = PW'(depth);

    logic [PW-1:0] wptr_gray_sync_w;
    logic [PW-1:0] wptr_bin_next;
    logic [PW-1:0] wptr_bin_sync_reg;
    logic          wptr_adv_reg;
    logic          wptr_adv_next;

    // Clock-domain crossing of the gray pointer.
    sync_ff_chain #(
        .W      (PW),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk_r),
        .rst_n (rst_r_gen),
        .d     (wptr_gray_w),
        .q     (wptr_gray_sync_w)
    );

    assign wptr_gray_sync = wptr_gray_sync_w;

    // Gray to binary decode, one XOR-reduction per bit.
    // This computes the same result as gray2bin() without widening to MAX_PW.
    for (genvar gi = 0; gi < PW; gi++) begin : g_decode
        assign wptr_bin_next[gi] = ^(wptr_gray_sync_w >> gi);
    end

    // A change of the decoded value, by any step size, gives one pulse.
    assign wptr_adv_next = (wptr_bin_next != wptr_bin_sync_reg);

    // Register the decoded pointer and the advance pulse.
    always_ff @(posedge clk_r or negedge rst_r_gen) begin
        if (!rst_r_gen) begin
            wptr_bin_sync_reg <= '0;
            wptr_adv_reg      <= 1'b0;
        end else begin
            wptr_bin_sync_reg <= wptr_bin_next;
            wptr_adv_reg      <= wptr_adv_next;
        end
    end

    assign wptr_bin_sync = wptr_bin_sync_reg;
    assign wptr_adv      = wptr_adv_reg;

    // Modulo-2^PW subtraction. The lap bit makes the wrap work without a special case.
    assign rd_level     = wptr_bin_sync_reg - rptr;
    assign almost_empty = (rd_level <= AE_LIMIT);

`ifdef WPTR_SYNC_CHECK_EN
    logic sync_err_reg;

    // Sticky flag. A level above depth means overflow or a corrupted pointer.
    always_ff @(posedge clk_r or negedge rst_r_gen) begin
        if (!rst_r_gen) begin
            sync_err_reg <= 1'b0;
        end else if (rd_level > LEVEL_LIMIT) begin
            sync_err_reg <= 1'b1;
        end
    end

    assign sync_err = sync_err_reg;
`else
    assign sync_err = 1'b0;
`endif

endmodule

// File: tb/tb_wptr_sync_r.sv
// Bench for wptr_sync_r with depth=16, PW=5, SYNC_STAGES=2, AE_THRESH=1.
// The stimulus writes binary pointer values as gray code and queues each
// expected binary pointer. A monitor pops the queue on every wptr_adv pulse.
// Fill level and flag checks use the model pointer, not values read from the DUT.
module tb_wptr_sync_r;

    localparam int PW = 5;

    logic          clk_r = 1'b0;
    logic          rst_r_gen = 1'b0;
    logic [PW-1:0] wptr_gray_w = '0;
    logic [PW-1:0] rptr = '0;
    logic [PW-1:0] wptr_gray_sync;
    logic [PW-1:0] wptr_bin_sync;
    logic          wptr_adv;
    logic [PW-1:0] rd_level;
    logic          almost_empty;
    logic          sync_err;

    int            n_total = 0;
    int            n_pass  = 0;
    int            adv_seen = 0;
    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] model_bin = '0;
    logic          err_exp;

    wptr_sync_r #(
        .depth       (16),
        .SYNC_STAGES (2),
        .AE_THRESH   (1)
    ) dut (
        .clk_r          (clk_r),
        .rst_r_gen      (rst_r_gen),
        .wptr_gray_w    (wptr_gray_w),
        .rptr           (rptr),
        .wptr_gray_sync (wptr_gray_sync),
        .wptr_bin_sync  (wptr_bin_sync),
        .wptr_adv       (wptr_adv),
        .rd_level       (rd_level),
        .almost_empty   (almost_empty),
        .sync_err       (sync_err)
    );

    always #5 clk_r = ~clk_r;

    function automatic logic [PW-1:0] to_gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_r);
        #1;
    endtask

    // Write one binary pointer value as gray and hold it long enough to cross.
    task automatic write_bin(input logic [PW-1:0] b);
        if (b != model_bin) exp_q.push_back(b);
        model_bin   = b;
        wptr_gray_w = to_gray(b);
        $display("write bin=%02h gray=%02h rptr=%02h", b, to_gray(b), rptr);
        step(4);
    endtask

    // Expected level from plain modular arithmetic on the model pointer.
    task automatic check_level(input string name);
        logic [PW-1:0] lv;
        lv = model_bin - rptr;
        chk({name, "_level"}, rd_level, lv);
        chk({name, "_ae"}, almost_empty, (lv <= 1));
    endtask

    // Scoreboard monitor: every advance pulse must match the next queued pointer.
    always @(negedge clk_r) begin
        if (wptr_adv === 1'b1) begin
            adv_seen++;
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL adv_extra: got pulse with bin=%02h, expected no pulse", wptr_bin_sync);
            end else begin
                logic [PW-1:0] e;
                e = exp_q.pop_front();
                chk("adv_bin", wptr_bin_sync, e);
                chk("adv_gray", wptr_gray_sync, to_gray(e));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int adv_base;
`ifdef WPTR_SYNC_CHECK_EN
        err_exp = 1'b1;
`else
        err_exp = 1'b0;
`endif
        // Test 1: reset values, then latency after release.
        wptr_gray_w = 5'h1F;
        #3;
        chk("rst_gray", wptr_gray_sync, 0);
        chk("rst_bin", wptr_bin_sync, 0);
        chk("rst_adv", wptr_adv, 0);
        chk("rst_err", sync_err, 0);
        chk("rst_level", rd_level, 0);
        chk("rst_ae", almost_empty, 1);
        step(1);
        rst_r_gen = 1'b1;
        model_bin = 5'h15;
        exp_q.push_back(5'h15);
        $display("release reset gray_w=1F");
        step(1);
        chk("lat_e1_gray", wptr_gray_sync, 0);
        step(1);
        chk("lat_e2_gray", wptr_gray_sync, 5'h1F);
        chk("lat_e2_bin", wptr_bin_sync, 0);
        chk("lat_e2_adv", wptr_adv, 0);
        step(1);
        chk("lat_e3_bin", wptr_bin_sync, 5'h15);
        chk("lat_e3_adv", wptr_adv, 1);
        step(1);
        chk("lat_e4_adv", wptr_adv, 0);

        // Test 2: full gray count with wrap back to 0.
        adv_base = adv_seen;
        for (int v = 0; v < 32; v++) begin
            write_bin(5'(v));
            check_level("count");
        end
        write_bin(5'h00);
        chk("count_bin_wrap", wptr_bin_sync, 0);
        chk("count_pulses", adv_seen - adv_base, 33);

        // Test 6: multi-step jump gives a single pulse.
        adv_base = adv_seen;
        write_bin(5'h05);
        chk("jump_gray_in", wptr_gray_w, 5'h07);
        chk("jump_bin", wptr_bin_sync, 5'h05);
        chk("jump_pulses", adv_seen - adv_base, 1);

        // Random pointer walk with random read pointers.
        for (int i = 0; i < 20; i++) begin
            write_bin(5'($urandom_range(0, 31)));
            rptr = 5'($urandom);
            #1;
            check_level("rand");
        end
        rptr = '0;

        // Test 5: asynchronous reset mid-stream, then resync.
        write_bin(5'h09);
        #2;
        rst_r_gen = 1'b0;
        #1;
        $display("async reset at bin=09");
        chk("mrst_gray", wptr_gray_sync, 0);
        chk("mrst_bin", wptr_bin_sync, 0);
        chk("mrst_adv", wptr_adv, 0);
        chk("mrst_err", sync_err, 0);
        chk("mrst_ae", almost_empty, 1);
        step(1);
        rst_r_gen = 1'b1;
        exp_q.push_back(5'h09);
        step(1);
        chk("mrst_e1_bin", wptr_bin_sync, 0);
        step(1);
        chk("mrst_e2_bin", wptr_bin_sync, 0);
        step(1);
        chk("mrst_e3_bin", wptr_bin_sync, 5'h09);
        chk("mrst_e3_adv", wptr_adv, 1);
        step(2);

        // Test 3: levels, with legal transitions between the points.
        rptr = 5'h09;
        write_bin(5'h12);
        rptr = 5'h0F;
        #1;
        chk("lvl_a", rd_level, 3);
        check_level("lvl_a");
        rptr = 5'h12;
        write_bin(5'h1F);
        rptr = 5'h1E;
        write_bin(5'h02);
        chk("lvl_b", rd_level, 4);
        check_level("lvl_b");
        rptr = 5'h02;
        write_bin(5'h12);
        rptr = 5'h11;
        #1;
        chk("lvl_c", rd_level, 1);
        chk("lvl_c_ae", almost_empty, 1);

        // Test 4: overflow check.
        chk("err_before", sync_err, 0);
        write_bin(5'h11);
        rptr = 5'h00;
        #1;
        chk("ovf_level", rd_level, 17);
        chk("ovf_err_pre_edge", sync_err, 0);
        step(1);
        chk("ovf_err", sync_err, err_exp);
        rptr = 5'h11;
        step(2);
        chk("ovf_err_sticky", sync_err, err_exp);

        step(4);
        chk("queue_drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
